// File: rtl/mem_array_arbiter_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_array_arbiter_pkg : data width, arbiter FSM state type, index helper
// Revision 1.0
// ------------------------------------------------------------------
package mem_array_arbiter_pkg;

  localparam int BUSWIDTH = 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arbState_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_array_arbiter_rr_picker.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_array_arbiter_rr_picker : combinational winner select; round-robin
// from ptr+1, or lowest-index-wins when MEMARB_FIXED_PRI_EN is defined.
// Revision 1.0
// ------------------------------------------------------------------
module mem_array_arbiter_rr_picker
  import mem_array_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
`ifndef MEMARB_FIXED_PRI_EN
  input  logic [IW-1:0]   ptr,
`endif
  output logic [NREQ-1:0] winner_oh,
  output logic [IW-1:0]   winner_idx,
  output logic            any_req
);

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    any_req    = |req;
`ifdef MEMARB_FIXED_PRI_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        winner_oh    = '0;
        winner_oh[k] = 1'b1;
        winner_idx   = IW'(k);
      end
    end
`else
    // Walk the search order backwards so the earliest candidate is the last write.
    for (int k = NREQ; k >= 1; k--) begin
      if (req[IW'((int'(ptr) + k) % NREQ)]) begin
        winner_oh  = '0;
        winner_idx = IW'((int'(ptr) + k) % NREQ);
        winner_oh[IW'((int'(ptr) + k) % NREQ)] = 1'b1;
      end
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/mem_array_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_array_arbiter : shares one memory array among NREQ requesters, one
// 3-cycle access at a time. MEMARB_FIXED_PRI_EN selects fixed priority.
// Revision 1.0
// ------------------------------------------------------------------
module mem_array_arbiter
  import mem_array_arbiter_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int ADDRWIDTH = 12
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          rdNwr,
  input  logic [NREQ*ADDRWIDTH-1:0] reqAddr,
  input  logic [NREQ*BUSWIDTH-1:0] reqData,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [BUSWIDTH-1:0]      rdData,
  output logic [ADDRWIDTH-1:0]     Addr,
  output logic [BUSWIDTH-1:0]      DataIn,
  output logic                     rdEn,
  output logic                     wrEn,
  input  logic [BUSWIDTH-1:0]      DataOut
);

  localparam int IW = idx_width(NREQ);

  arbState_t             state, state_nxt;
  logic [NREQ-1:0]       pick_oh, own_oh;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;
  logic                  own_rd;
  logic [ADDRWIDTH-1:0]  own_addr;
  logic [BUSWIDTH-1:0]   own_data;
  logic [ADDRWIDTH-1:0]  addr_v [NREQ];
  logic [BUSWIDTH-1:0]   data_v [NREQ];
`ifndef MEMARB_FIXED_PRI_EN
  logic [IW-1:0]         ptr, own_idx;
`endif

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_v[i] = reqAddr[i*ADDRWIDTH +: ADDRWIDTH];
    assign data_v[i] = reqData[i*BUSWIDTH +: BUSWIDTH];
  end

  mem_array_arbiter_rr_picker #(
    .NREQ(NREQ)
  ) u_picker (
    .req        (req),
`ifndef MEMARB_FIXED_PRI_EN
    .ptr        (ptr),
`endif
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .any_req    (pick_any)
  );

  // The request is captured only at the grant decision; later input changes are ignored.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= ARB_IDLE;
      own_oh   <= '0;
      own_rd   <= 1'b0;
      own_addr <= '0;
      own_data <= '0;
      done     <= '0;
      rdData   <= '0;
    end else begin
      state <= state_nxt;
      done  <= '0;
      if (state == ARB_IDLE && pick_any) begin
        own_oh   <= pick_oh;
        own_rd   <= rdNwr[pick_idx];
        own_addr <= addr_v[pick_idx];
        own_data <= data_v[pick_idx];
      end
      if (state == ARB_RESP) begin
        done <= own_oh;
        if (own_rd) rdData <= DataOut;
      end
    end
  end

`ifndef MEMARB_FIXED_PRI_EN
  // Pointer resets to the last requester so requester 0 is searched first.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ptr     <= IW'(NREQ - 1);
      own_idx <= '0;
    end else begin
      if (state == ARB_IDLE && pick_any) own_idx <= pick_idx;
      if (state == ARB_RESP) ptr <= own_idx;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    Addr      = '0;
    DataIn    = '0;
    rdEn      = 1'b0;
    wrEn      = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_any) state_nxt = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        state_nxt = ARB_RESP;
        gnt       = own_oh;
        Addr      = own_addr;
        DataIn    = own_data;
        rdEn      = own_rd;
        wrEn      = ~own_rd;
      end
      ARB_RESP: begin
        state_nxt = ARB_IDLE;
        gnt       = own_oh;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_array_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_mem_array_arbiter : directed literal checks plus random traffic against
// a transaction-level schedule model and an array model.
// Revision 1.0
// ------------------------------------------------------------------
module tb_mem_array_arbiter;
  import mem_array_arbiter_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 12;
  localparam int BW   = BUSWIDTH;

  logic                 clk     = 1'b0;
  logic                 resetN  = 1'b0;
  logic [NREQ-1:0]      req     = '0;
  logic [NREQ-1:0]      rdNwr   = '0;
  logic [NREQ*AW-1:0]   reqAddr = '0;
  logic [NREQ*BW-1:0]   reqData = '0;
  logic [NREQ-1:0]      gnt, done;
  logic [BW-1:0]        rdData, DataIn;
  logic [BW-1:0]        DataOut = '0;
  logic [AW-1:0]        Addr;
  logic                 rdEn, wrEn;

  int n_chk  = 0;
  int n_fail = 0;

  mem_array_arbiter #(.NREQ(NREQ), .ADDRWIDTH(AW)) dut (
    .clk(clk), .resetN(resetN), .req(req), .rdNwr(rdNwr),
    .reqAddr(reqAddr), .reqData(reqData), .gnt(gnt), .done(done),
    .rdData(rdData), .Addr(Addr), .DataIn(DataIn), .rdEn(rdEn),
    .wrEn(wrEn), .DataOut(DataOut)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] pattern(input int a);
    return BW'(a[7:0] ^ 8'h5A);
  endfunction

  function automatic logic bitv(input logic [NREQ-1:0] v, input int j);
    return ((v >> j) & NREQ'(1)) != '0;
  endfunction

  // Memory array: write on wrEn, read data available the cycle after rdEn.
  logic [BW-1:0] arr [1<<AW];
  bit arr_init = 1'b0;
  always @(posedge clk) begin
    if (!arr_init) begin
      for (int a = 0; a < (1 << AW); a++) arr[a] = pattern(a);
      arr_init = 1'b1;
    end
    if (wrEn) arr[Addr] = DataIn;
    if (rdEn) DataOut <= arr[Addr];
  end

  // Schedule model: a grant decided at edge n owns slots n, n+1, n+2.
  typedef struct packed {
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] d;
    logic [AW-1:0]   a;
    logic [BW-1:0]   di;
    logic            rd;
    logic            wr;
    logic            upd;
    logic [BW-1:0]   rv;
  } slot_t;

  slot_t         ring [4];
  slot_t         cur      = '0;
  logic [BW-1:0] m_rddata = '0;
  logic [BW-1:0] gold [1<<AW];
  bit            gold_init = 1'b0;
  int            cyc = 0;
  int            next_dec = 0;
`ifndef MEMARB_FIXED_PRI_EN
  int            m_ptr = NREQ - 1;
`endif

  always @(posedge clk or negedge resetN) begin
    int            w;
    logic [AW-1:0] a;
    logic [BW-1:0] d;
    logic          rd;
    if (!gold_init) begin
      for (int k = 0; k < (1 << AW); k++) gold[k] = pattern(k);
      gold_init = 1'b1;
    end
    if (!resetN) begin
      for (int s = 0; s < 4; s++) ring[s] = '0;
      cur      = '0;
      m_rddata = '0;
      next_dec = cyc + 1;
`ifndef MEMARB_FIXED_PRI_EN
      m_ptr    = NREQ - 1;
`endif
    end else begin
      cyc++;
      if (cyc >= next_dec) begin
        next_dec = cyc + 1;
        w = -1;
`ifdef MEMARB_FIXED_PRI_EN
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && bitv(req, k)) w = k;
`else
        for (int k = 1; k <= NREQ; k++)
          if (w < 0 && bitv(req, (m_ptr + k) % NREQ)) w = (m_ptr + k) % NREQ;
`endif
        if (w >= 0) begin
          a  = AW'(reqAddr >> (w * AW));
          d  = BW'(reqData >> (w * BW));
          rd = bitv(rdNwr, w);
          ring[cyc % 4].g        = NREQ'(1) << w;
          ring[cyc % 4].a        = a;
          ring[cyc % 4].di       = d;
          ring[cyc % 4].rd       = rd;
          ring[cyc % 4].wr       = ~rd;
          ring[(cyc + 1) % 4].g  = NREQ'(1) << w;
          ring[(cyc + 2) % 4].d  = NREQ'(1) << w;
          if (rd) begin
            ring[(cyc + 2) % 4].upd = 1'b1;
            ring[(cyc + 2) % 4].rv  = gold[a];
          end else begin
            gold[a] = d;
          end
`ifndef MEMARB_FIXED_PRI_EN
          m_ptr = w;
`endif
          next_dec = cyc + 3;
        end
      end
      cur = ring[cyc % 4];
      ring[cyc % 4] = '0;
      if (cur.upd) m_rddata = cur.rv;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v);
    logic [NREQ-1:0] m;
    m   = NREQ'(1) << i;
    req = v ? (req | m) : (req & ~m);
  endtask

  task automatic drive(input int i, input logic r, input logic rd,
                       input logic [AW-1:0] a, input logic [BW-1:0] d);
    logic [NREQ-1:0]    m;
    logic [NREQ*AW-1:0] am;
    logic [NREQ*BW-1:0] dm;
    m       = NREQ'(1) << i;
    am      = (NREQ*AW)'({AW{1'b1}}) << (i * AW);
    dm      = (NREQ*BW)'({BW{1'b1}}) << (i * BW);
    rdNwr   = rd ? (rdNwr | m) : (rdNwr & ~m);
    reqAddr = (reqAddr & ~am) | ((NREQ*AW)'(a) << (i * AW));
    reqData = (reqData & ~dm) | ((NREQ*BW)'(d) << (i * BW));
    set_req(i, r);
  endtask

  task automatic reset_dut;
    resetN = 1'b0;
    repeat (2) tick;
    resetN = 1'b1;
  endtask

  // Single access from an idle arbiter, with literal timing expectations.
  task automatic op(input int i, input logic rd, input logic [AW-1:0] a,
                    input logic [BW-1:0] d, input logic drop, input logic [BW-1:0] exp_rd);
    drive(i, 1'b1, rd, a, d);
    tick;
    chk("op_gnt",  32'(gnt),    32'(1) << i);
    chk("op_rdEn", 32'(rdEn),   32'(rd));
    chk("op_wrEn", 32'(wrEn),   32'(!rd));
    chk("op_addr", 32'(Addr),   32'(a));
    chk("op_din",  32'(DataIn), 32'(d));
    drive(i, !drop, rd, ~a, ~d);
    tick;
    chk("op_resp_gnt",  32'(gnt),  32'(1) << i);
    chk("op_resp_done", 32'(done), 32'(0));
    chk("op_resp_en",   32'({rdEn, wrEn}), 32'(0));
    tick;
    chk("op_done", 32'(done), 32'(1) << i);
    if (rd) chk("op_rdData", 32'(rdData), 32'(exp_rd));
    set_req(i, 1'b0);
  endtask

  initial begin
    int exp;
    fork
      forever begin
        @(negedge clk);
        if (cyc > 0) begin
          chk("m_gnt",    32'(gnt),    32'(cur.g));
          chk("m_done",   32'(done),   32'(cur.d));
          chk("m_rdData", 32'(rdData), 32'(m_rddata));
          chk("m_addr",   32'(Addr),   32'(cur.a));
          chk("m_din",    32'(DataIn), 32'(cur.di));
          chk("m_rdEn",   32'(rdEn),   32'(cur.rd));
          chk("m_wrEn",   32'(wrEn),   32'(cur.wr));
          chk("m_excl",   32'(rdEn & wrEn), 32'(0));
        end
      end
    join_none

    reset_dut;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("idle_gnt",  32'(gnt),  32'(0));
      chk("idle_done", 32'(done), 32'(0));
      chk("idle_en",   32'({rdEn, wrEn}), 32'(0));
      chk("idle_addr", 32'(Addr), 32'(0));
    end
    chk("idle_rdData", 32'(rdData), 32'(0));

    op(0, 1'b0, 12'h123, 8'hA5, 1'b0, 8'h00);
    op(0, 1'b1, 12'h123, 8'h00, 1'b0, 8'hA5);
    op(1, 1'b1, 12'h040, 8'h00, 1'b1, 8'h1A);

    // Contention after reset: requesters 0 and 1 hold reads continuously.
    reset_dut;
    drive(0, 1'b1, 1'b1, 12'h010, 8'h00);
    drive(1, 1'b1, 1'b1, 12'h020, 8'h00);
    for (int k = 0; k < 4; k++) begin
`ifdef MEMARB_FIXED_PRI_EN
      exp = 0;
`else
      exp = k % 2;
`endif
      tick;
      chk("cont_gnt", 32'(gnt), 32'(1) << exp);
      tick;
      tick;
      chk("cont_done", 32'(done), 32'(1) << exp);
      chk("cont_rdData", 32'(rdData), (exp == 0) ? 32'h4A : 32'h7A);
    end
    set_req(0, 1'b0);
    tick;
    chk("cont_gnt1", 32'(gnt), 32'(2));
    set_req(1, 1'b0);
    tick;
    tick;
    chk("cont_done1", 32'(done), 32'(2));

    // Reset during the ACCESS cycle of a write.
    drive(0, 1'b1, 1'b0, 12'h050, 8'h3C);
    tick;
    chk("rst_wrEn_pre", 32'(wrEn), 32'(1));
    #1 resetN = 1'b0;
    #1;
    chk("rst_wrEn_async", 32'(wrEn), 32'(0));
    chk("rst_gnt_async",  32'(gnt),  32'(0));
    tick;
    chk("rst_done_a", 32'(done), 32'(0));
    tick;
    chk("rst_done_b", 32'(done), 32'(0));
    resetN = 1'b1;
    drive(1, 1'b1, 1'b1, 12'h101, 8'h00);
    drive(2, 1'b1, 1'b1, 12'h102, 8'h00);
    tick;
    chk("rst_first_gnt", 32'(gnt), 32'(1));
    req = '0;
    repeat (4) tick;

    // Random traffic, checked every cycle by the model.
    for (int c = 0; c < 1500; c++) begin
      tick;
      for (int i = 0; i < NREQ; i++) begin
        if (!bitv(req, i)) begin
          if ($urandom_range(0, 2) == 0)
            drive(i, 1'b1, 1'($urandom_range(0, 1)), AW'(12'h100 + $urandom_range(0, 15)), BW'($urandom));
        end else if (bitv(done, i)) begin
          if ($urandom_range(0, 3) != 0) set_req(i, 1'b0);
          else drive(i, 1'b1, 1'($urandom_range(0, 1)), AW'(12'h100 + $urandom_range(0, 15)), BW'($urandom));
        end else if (bitv(gnt, i)) begin
          case ($urandom_range(0, 7))
            0:       set_req(i, 1'b0);
            1, 2:    drive(i, 1'b1, bitv(rdNwr, i), AW'($urandom), BW'($urandom));
            default: ;
          endcase
        end
      end
    end
    req = '0;
    repeat (5) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_array_arbiter.md
Name: mem_array_arbiter

Overview:
Shares the single memory array among NREQ requester ports, one access at a time. Each requester is typically a memory interface unit.
- Grants access by round-robin, sequences rdEn/wrEn to the array, captures read data and returns a one-cycle done pulse.
- Becomes the sole driver of the array-side Addr/DataIn/rdEn/wrEn nets.

Parameters:
NREQ, 2, number of requesters (2..8).
ADDRWIDTH, 12, memory array address width.
BUSWIDTH, from mcDefs, data width (package constant, not overridden).

Ports:
clk  input  1  system clock; all state on rising edge.
resetN  input  1  asynchronous active-low reset.
req  input  NREQ  per-requester access request; held until done.
rdNwr  input  NREQ  per-requester op: 1=read, 0=write; stable while req.
reqAddr  input  NREQ*ADDRWIDTH  packed addresses; slice i is requester i.
reqData  input  NREQ*BUSWIDTH  packed write data.
gnt  output  NREQ  one-hot; high from ACCESS through RESP for the owner.
done  output  NREQ  one-cycle pulse to the owner at end of RESP.
rdData  output  BUSWIDTH  read data; valid when done pulses for a read.
Addr  output  ADDRWIDTH  to array.
DataIn  output  BUSWIDTH  to array.
rdEn  output  1  to array, active high.
wrEn  output  1  to array, active high.
DataOut  input  BUSWIDTH  from array; valid the cycle after rdEn.

Behaviour:
- Reset (resetN low, async) forces the following. Outputs: gnt=0, done=0, rdData=0, Addr=0, DataIn=0, rdEn=0, wrEn=0. Internal: state=IDLE, rr pointer=NREQ-1 (so requester 0 wins first).
- FSM IDLE -> ACCESS -> RESP -> IDLE. Every access costs exactly 3 cycles; back-to-back sustained throughput is 1 op per 3 cycles.
- IDLE:
  - If any req, pick the winner by searching from (ptr+1) mod NREQ upward and latch its index, op, addr and data.
  - Go to ACCESS; gnt[winner]=1 from the next cycle.
  - If no req, stay in IDLE with array outputs at 0.
- ACCESS:
  - Drive the latched Addr and DataIn.
  - Assert rdEn (read) or wrEn (write) for exactly this one cycle.
  - Never assert rdEn and wrEn together.
- RESP:
  - Read: register DataOut into rdData at the end of the cycle.
  - Pulse done[winner]; rdData is valid at this pulse and holds until the next read completes. Writes do not alter rdData.
  - ptr <= winner; gnt cleared at exit; Addr/DataIn/en return to 0.
- Requests are latched in IDLE. Changes to req/addr/data after the grant decision are ignored.
- If req drops before done, the access still completes and done still pulses.
- If req is still high in IDLE after done, it is a new request and is arbitrated normally; round-robin guarantees other waiting requesters are served first.
- Simultaneous requests: exactly one grant; the others wait, and no request is lost while held.
- Single requester continuously asserting: served every 3 cycles.
- Reset mid-ACCESS: rdEn/wrEn drop immediately (async), no done is issued, and the requester must reissue.
- The arbiter drives Addr/DataIn/rdEn/wrEn continuously, never Z. It is the only driver on those shared nets.

Optional Feature:
MEMARB_FIXED_PRI_EN.
- Defined: fixed priority, lowest index wins; the rr pointer is not implemented. Starvation of high indices is permitted.
- Undefined (default): round-robin as above.
- Timing and handshake are identical in both modes.

Decomposition:
- mcDefs package: BUSWIDTH (existing); add typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arbState_t.
- One natural sub-module, rr_picker: combinational; inputs req vector and ptr; outputs one-hot winner plus index. The macro selects its fixed-priority variant.
- The top level holds the FSM, latches and array drive.

Test Plan:
- Reset then idle: resetN=0 for 2 cycles, then no req for 5 cycles -> all outputs 0, rdEn=wrEn=0.
- Write then read, requester 0: write addr 0x123 data 0xA5; then read 0x123 -> wrEn 1 cycle with Addr=0x123, DataIn=0xA5; done[0] pulses 3 cycles after each request; rdData=0xA5 at the read done.
- Contention, NREQ=2: req=2'b11 held continuously with reads to 0x010/0x020 -> grants alternate 0,1,0,1; each done 3 cycles apart; no rdEn/wrEn overlap.
- Early drop: requester 1 read at 0x040, req deasserted in ACCESS -> done[1] still pulses in RESP; rdData = array content at 0x040.
- Reset mid-op: resetN low during ACCESS of a write -> wrEn falls asynchronously, no done; after release, requester 0 is served first.
- MEMARB_FIXED_PRI_EN defined, req=2'b11 held -> requester 0 granted every time; requester 1 never granted until req[0] drops.
